inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction fetch front end for the single-cycle CPU. It keeps its own fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. Returned instructions go into a DEPTH-entry FIFO and are presented to the decode stage (op/func/rs/rt/rd/sa/imm/addr split) with valid/ready, together with the instruction's PC and PC+4, which is used as the jal link value. Branch, jr and j/jal targets arrive on the redirect port and flush the queue.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2 to 16.
- RESET_PC, 32'h0000_0000: first fetch address after reset; word aligned.

Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous and active-high.
- imem_req  out  1  request valid; held until imem_ack.
- imem_addr  out  32  word address of the request; stable while imem_req=1.
- imem_ack  in  1  data valid this cycle for the outstanding request.
- imem_data  in  32  instruction word; sampled only when imem_ack=1.
- redirect  in  1  control-flow change; flush the queue and refetch.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  head entry valid.
- inst  out  32  head instruction.
- inst_pc  out  32  address of the head instruction.
- inst_pc4  out  32  inst_pc + 4, modulo 2^32.
- inst_ready  in  1  decode consumes the head entry when inst_valid=1 and inst_ready=1.
- count  out  $clog2(DEPTH)+1  number of valid FIFO entries.

## Operation
- State: fetch_pc (next address to request), FIFO storage of {pc, data}, rd_ptr, wr_ptr, count, and an FSM with states IDLE, WAIT and DRAIN.
- IDLE
  - If count + (incoming push) − (pop this cycle) < DEPTH: assert imem_req next cycle with imem_addr=fetch_pc, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT
  - imem_req=1 and imem_addr is held until imem_ack.
  - On ack: push {imem_addr, imem_data}, and set fetch_pc = imem_addr + 4 (32-bit wrap: FFFF_FFFC → 0000_0000).
  - If there is room after this push/pop, issue the next request in the following cycle (back-to-back; stay in WAIT with the new address). Otherwise go to IDLE with imem_req=0.
- DRAIN
  - Entered when redirect=1 while in WAIT without a simultaneous ack.
  - imem_req stays 1 with the old address; an outstanding request is never aborted.
  - On ack: discard the data and go to IDLE.
- Redirect (any state)
  - Flush: count=0 and rd_ptr=wr_ptr; set fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Redirect in WAIT together with ack: discard the data and go to IDLE (not DRAIN).
  - Redirect in DRAIN together with ack: go to IDLE; fetch_pc takes the newest redirect_pc.
  - Redirect in DRAIN without ack: stay in DRAIN; fetch_pc is updated.
- Pop: when inst_valid & inst_ready & ~redirect, advance rd_ptr.
  - Redirect wins over a simultaneous pop and a simultaneous push.
- Push and pop in the same cycle with the FIFO full is legal: count is unchanged.
- Pointers wrap modulo DEPTH.
- imem_ack in IDLE is ignored.
- inst, inst_pc and inst_pc4 are don't-care when inst_valid=0; they must not be X-propagating (hold the last value).

## Timing
- Reset (clr=1 at an edge): state IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, FIFO empty, count=0, inst_valid=0.
  - inst, inst_pc and inst_pc4 reset to 0 and 4.
  - Reset mid-transaction drops the outstanding request; a later ack is ignored because the FSM is in IDLE.
- First request: imem_req=1 in the first cycle after clr deasserts.
- Memory latency:
  - ack may come in the same cycle as req (zero-wait) or any later cycle.
  - Ack at edge N → inst_valid=1 after edge N+1 (registered FIFO, one cycle of latency).
- Throughput: one instruction per cycle with a zero-wait memory and inst_ready held high.
- Redirect sampled at edge N, no request outstanding → imem_req=1 with imem_addr=redirect_pc in the cycle after N. inst_valid=0 from N+1 until new data is pushed.
- Redirect with a request outstanding → the new request goes out in the cycle after the drained ack.
- Full FIFO with outstanding requests never overflows: room is checked including the in-flight request.

## Test plan
- Reset then free-run, zero-wait memory returning data=addr, inst_ready=1:
  - imem_addr sequence 0, 4, 8, …
  - inst_valid from cycle 2; inst_pc increments by 4 each cycle; inst_pc4 = inst_pc + 4.
- Backpressure, inst_ready=0, DEPTH=4:
  - Exactly 4 acks accepted; count=4; imem_req stays 0 once full.
  - Raise inst_ready: entries pop in order 0, 4, 8, C; fetching resumes at 0x10.
- Redirect while idle and full: redirect_pc=0x0000_0103.
  - count→0; next imem_addr=0x0000_0100.
  - A simultaneous inst_ready pop is not consumed.
- Redirect during a 3-cycle-latency request to 0x20:
  - imem_req held with addr 0x20 until ack; that data is discarded.
  - Next request goes to the redirect target; no 0x20 entry ever appears on inst_pc.
- Wrap-around: RESET_PC=0xFFFF_FFF8.
  - Fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - inst_pc4 for FFFF_FFFC is 0.
- Reset asserted while in WAIT: imem_req=0 the next cycle; a stale ack is ignored; refetch starts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: fetch PC, req/ack memory handshake, DEPTH-entry
// instruction FIFO with a registered head presented to decode, and redirect flush.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     clr,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic [31:0]              inst_pc4,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [31:0]   inst_q, inst_pc_q;

  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic          push, pop;
  logic [CW-1:0] level_after_pop;
  logic [31:0]   redir_addr, next_addr;

  assign redir_addr      = redirect_pc & ~32'h3;
  assign next_addr       = addr_q + 32'd4;
  assign pop             = valid_q & inst_ready & ~redirect;
  assign push            = (state_q == S_WAIT) & imem_ack & ~redirect;
  assign level_after_pop = count_q - CW'(pop);

  // Room is judged on the occupancy after this cycle's pop, so the request
  // about to go out always has a free slot waiting for it.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redir_addr;
          addr_d     = redir_addr;
          state_d    = S_WAIT;
        end else if (level_after_pop < DEPTH_C) begin
          addr_d  = fetch_pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redir_addr;
          state_d    = imem_ack ? S_IDLE : S_DRAIN;
        end else if (imem_ack) begin
          fetch_pc_d = next_addr;
          if (level_after_pop + CW'(1) < DEPTH_C) begin
            addr_d = next_addr;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_pc_d = redir_addr;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The head register only becomes valid once its entry was written on an
  // earlier edge, giving one cycle from ack to inst_valid.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (redirect) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
    valid_d = (count_d != '0) && !(push && (rd_ptr_d == wr_ptr_q));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= imem_data;
      mem_pc[wr_ptr_q]   <= addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      if (valid_d) begin
        inst_q    <= mem_data[rd_ptr_d];
        inst_pc_q <= mem_pc[rd_ptr_d];
      end
    end
  end

  assign imem_req   = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_pc4   = inst_pc_q + 32'd4;
  assign count      = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-based transaction model
// of the fetch stream, flush/drain rules and decode-side ordering.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;

  logic        clk;
  logic        clr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        inst_ready;
  logic [$clog2(DEPTH):0] count;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .clr(clr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
    .inst_ready(inst_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          e;
  } ent_t;

  ent_t        q[$];
  bit          m_req, m_drain, m_valid;
  logic [31:0] m_addr, m_fetch;
  int          edge_n;

  int total, bad;

  // stimulus knobs and memory responder state
  int lat_min, lat_max, ready_pct, redir_pct, ackidle_pct, clr_pct;
  bit rpc_fixed;
  logic [31:0] rpc_val;
  int wcnt, lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_step();
    bit   pop;
    ent_t e;
    edge_n++;
    if (clr) begin
      q.delete();
      m_req   = 1'b0;
      m_drain = 1'b0;
      m_fetch = RESET_PC;
      m_addr  = RESET_PC;
      return;
    end
    pop = m_valid && inst_ready && !redirect;
    if (redirect) begin
      q.delete();
      m_fetch = redirect_pc & ~32'h3;
      if (m_req && !imem_ack) begin
        m_drain = 1'b1;
      end else if (m_req) begin
        m_req   = 1'b0;
        m_drain = 1'b0;
      end else begin
        m_req  = 1'b1;
        m_addr = m_fetch;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (m_req && imem_ack) begin
        if (m_drain) begin
          m_drain = 1'b0;
          m_req   = 1'b0;
        end else begin
          e.pc   = m_addr;
          e.data = imem_data;
          e.e    = edge_n;
          q.push_back(e);
          m_fetch = m_addr + 32'd4;
          if (q.size() < DEPTH) m_addr = m_fetch;
          else                  m_req  = 1'b0;
        end
      end else if (!m_req) begin
        if (q.size() < DEPTH) begin
          m_req  = 1'b1;
          m_addr = m_fetch;
        end
      end
    end
  endtask

  // Starts and ends at a negedge: check, drive, step the model, advance a cycle.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      m_valid = (q.size() > 0) && (q[0].e < edge_n);
      chk("req", {31'b0, imem_req}, {31'b0, m_req});
      if (m_req) chk("addr", imem_addr, m_addr);
      chk("valid", {31'b0, inst_valid}, {31'b0, m_valid});
      chk("count", 32'(count), 32'(q.size()));
      if (m_valid) begin
        chk("inst", inst, q[0].data);
        chk("inst_pc", inst_pc, q[0].pc);
        chk("inst_pc4", inst_pc4, q[0].pc + 32'd4);
      end
      inst_ready  = ($urandom_range(99) < ready_pct);
      redirect    = ($urandom_range(99) < redir_pct);
      redirect_pc = rpc_fixed ? rpc_val : $urandom;
      clr         = ($urandom_range(99) < clr_pct);
      imem_data   = $urandom;
      if (imem_req) begin
        imem_ack = (wcnt >= lat);
        if (imem_ack) begin
          wcnt = 0;
          lat  = $urandom_range(lat_max, lat_min);
        end else begin
          wcnt++;
        end
      end else begin
        imem_ack = ($urandom_range(99) < ackidle_pct);
      end
      if (clr) wcnt = 0;
      model_step();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rdy,
                           input int rdr, input int aidle, input int cl);
    lat_min = lmin; lat_max = lmax; ready_pct = rdy;
    redir_pct = rdr; ackidle_pct = aidle; clr_pct = cl;
    lat = $urandom_range(lat_max, lat_min);
  endtask

  initial begin
    total = 0; bad = 0; edge_n = 0; wcnt = 0;
    rpc_fixed = 1'b0; rpc_val = '0;
    clr = 1'b1; imem_ack = 1'b0; imem_data = '0; redirect = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0;
    q.delete();
    m_req = 1'b0; m_drain = 1'b0; m_fetch = RESET_PC; m_addr = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_pc4", inst_pc4, 32'd4);

    // free run with a zero-wait memory; covers the 32-bit PC wrap
    set_knobs(0, 0, 100, 0, 0, 0);
    run_cycles(20);

    // backpressure until full
    set_knobs(0, 0, 0, 0, 0, 0);
    run_cycles(12);
    chk("full_count", 32'(count), DEPTH);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    set_knobs(0, 0, 100, 0, 0, 0);
    run_cycles(10);

    // redirect while idle and full, with a simultaneous ready
    set_knobs(0, 0, 0, 0, 0, 0);
    run_cycles(12);
    rpc_fixed = 1'b1; rpc_val = 32'h0000_0103;
    set_knobs(0, 0, 100, 100, 0, 0);
    run_cycles(1);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    set_knobs(0, 0, 100, 0, 0, 0);
    run_cycles(10);

    // redirect while a slow request is outstanding
    set_knobs(3, 3, 100, 0, 0, 0);
    run_cycles(6);
    rpc_val = 32'h0000_0040;
    set_knobs(3, 3, 100, 100, 0, 0);
    run_cycles(1);
    set_knobs(3, 3, 100, 0, 0, 0);
    run_cycles(16);
    rpc_fixed = 1'b0;

    // random traffic
    set_knobs(0, 3, 70, 4, 10, 1);
    run_cycles(3000);

    // reset while a request is outstanding, followed by a stale ack
    set_knobs(5, 5, 100, 0, 0, 0);
    for (int i = 0; i < 20 && !imem_req; i++) run_cycles(1);
    chk("wait_req", {31'b0, imem_req}, 32'd1);
    set_knobs(5, 5, 100, 0, 0, 100);
    run_cycles(1);
    chk("clr_req", {31'b0, imem_req}, 32'd0);
    set_knobs(0, 0, 100, 0, 100, 0);
    run_cycles(1);
    set_knobs(0, 0, 100, 0, 0, 0);
    run_cycles(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
